lane_density_sensor: RTL

Front-end vehicle-detection block that produces the per-lane traffic-request flags T1..T4 consumed by the traffic controller FSMs. It synchronizes and debounces four raw loop-detector/switch inputs and counts vehicle arrivals per lane over a fixed measurement window. At each window boundary it converts the counts into density flags with hysteresis. It sits between the board inputs and the T1..T4 inputs of the traffic controller, in the CLK_100MHZ domain.

---
 rtl/lane_density_sensor_pkg.sv | 29 ++
 rtl/lane_density_sensor_if.sv | 13 +
 rtl/lane_density_sensor_debounce.sv | 60 ++++++
 rtl/lane_density_sensor.sv | 97 +++++++++
 4 files changed

// File: rtl/lane_density_sensor_pkg.sv
// Shared constants for the lane density sensor and the traffic controller top.
// Lane i of every vector maps to controller request T(i+1).
package lane_density_sensor_pkg;

    localparam int NUM_LANES        = 4;

    localparam int TICK_DIV_DEF     = 100_000;  // 1 kHz sample tick at 100 MHz
    localparam int DEB_TICKS_DEF    = 10;
    localparam int WINDOW_TICKS_DEF = 5000;     // 5 s measurement window
    localparam int CNT_W_DEF        = 6;
    localparam int HI_TH_DEF        = 4;
    localparam int LO_TH_DEF        = 2;

    typedef logic [NUM_LANES-1:0] lane_vec_t;

    // Density flag with hysteresis: set at or above hi, clear at or below lo,
    // otherwise keep the previous decision.
    function automatic logic hyst_flag(input logic cur, input int cnt, input int hi, input int lo);
        logic flag;
        flag = cur;
        if (cnt >= hi) begin
            flag = 1'b1;
        end else if (cnt <= lo) begin
            flag = 1'b0;
        end
        return flag;
    endfunction

endpackage

// File: rtl/lane_density_sensor_if.sv
// Detector inputs and density outputs of the lane density sensor.
// master = board/controller side, slave = the sensor itself.
interface lane_density_sensor_if #(
    parameter int CNT_W = lane_density_sensor_pkg::CNT_W_DEF
);
    logic [lane_density_sensor_pkg::NUM_LANES-1:0]       DET;
    logic [lane_density_sensor_pkg::NUM_LANES-1:0]       T;
    logic                                                WIN_DONE;
    logic [lane_density_sensor_pkg::NUM_LANES*CNT_W-1:0] LAST_CNT;

    modport master (output DET, input T, input WIN_DONE, input LAST_CNT);
    modport slave  (input DET, output T, output WIN_DONE, output LAST_CNT);
endinterface

// File: rtl/lane_density_sensor_debounce.sv
// One lane front end: 2-flop synchronizer, tick-based debouncer and a
// vehicle-event pulse on the rising edge of the debounced level.
// The event pulse is asserted in the same cycle as the tick that flips the
// level, so it can coincide with the window terminal tick in the top.
module lane_debounce #(
    parameter int DEB_TICKS = lane_density_sensor_pkg::DEB_TICKS_DEF
) (
    input  logic CLK_100MHZ,
    input  logic RESET,
    input  logic tick_i,
    input  logic raw_i,
    output logic event_o
);
    localparam int DEB_W = $clog2(DEB_TICKS + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;
    logic             differ;
    logic             flip;

    assign differ  = (sync2_q != level_q);
    assign flip    = tick_i && differ && (deb_cnt_q == DEB_W'(DEB_TICKS - 1));
    assign event_o = flip && !level_q;

    // Count consecutive differing samples; accept the new level on the last one.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        if (tick_i) begin
            if (!differ) begin
                deb_cnt_d = '0;
            end else if (flip) begin
                deb_cnt_d = '0;
                level_d   = !level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Synchronizer and debounce state.
    always_ff @(posedge CLK_100MHZ or posedge RESET) begin
        if (RESET) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

endmodule

// File: rtl/lane_density_sensor.sv
// Lane density sensor top: sample tick, measurement window, per-lane vehicle
// counters and hysteresis flags. T/LAST_CNT/WIN_DONE only move on the
// terminal tick of a window, so T is stable for a slow-clock consumer.
module lane_density_sensor
    import lane_density_sensor_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int DEB_TICKS    = DEB_TICKS_DEF,
    parameter int WINDOW_TICKS = WINDOW_TICKS_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int HI_TH        = HI_TH_DEF,
    parameter int LO_TH        = LO_TH_DEF
) (
    input  logic                 CLK_100MHZ,
    input  logic                 RESET,
    lane_density_sensor_if.slave bus
);
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int WIN_W  = $clog2(WINDOW_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [TICK_W-1:0]          tick_cnt_q;
    logic [TICK_W-1:0]          tick_cnt_d;
    logic [WIN_W-1:0]           win_cnt_q;
    logic [WIN_W-1:0]           win_cnt_d;
    logic                       tick;
    logic                       terminal;
    lane_vec_t                  lane_event;
    logic [CNT_W-1:0]           lane_cnt_q [NUM_LANES];
    logic [CNT_W-1:0]           lane_cnt_d [NUM_LANES];
    logic [CNT_W-1:0]           final_cnt  [NUM_LANES];
    lane_vec_t                  t_q;
    lane_vec_t                  t_d;
    logic [NUM_LANES*CNT_W-1:0] last_cnt_q;
    logic [NUM_LANES*CNT_W-1:0] last_cnt_d;
    logic                       win_done_q;

    assign tick     = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign terminal = tick && (win_cnt_q == WIN_W'(WINDOW_TICKS - 1));

    // Next state of the tick divider and the window tick counter.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        win_cnt_d  = win_cnt_q;
        if (tick) begin
            win_cnt_d = terminal ? '0 : win_cnt_q + WIN_W'(1);
        end
    end

    // Per-lane front end, saturating counter and flag update. An event on the
    // terminal tick is folded into the closing window's final count.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic inc;

            lane_debounce #(.DEB_TICKS(DEB_TICKS)) u_debounce (
                .CLK_100MHZ (CLK_100MHZ),
                .RESET      (RESET),
                .tick_i     (tick),
                .raw_i      (bus.DET[gi]),
                .event_o    (lane_event[gi])
            );

            assign inc           = lane_event[gi] && (lane_cnt_q[gi] != CNT_MAX);
            assign final_cnt[gi] = lane_cnt_q[gi] + CNT_W'(inc);
            assign lane_cnt_d[gi] = terminal ? '0 : final_cnt[gi];
            assign t_d[gi] = terminal ? hyst_flag(t_q[gi], int'(final_cnt[gi]), HI_TH, LO_TH)
                                      : t_q[gi];
            assign last_cnt_d[gi*CNT_W +: CNT_W] = terminal ? final_cnt[gi]
                                                            : last_cnt_q[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // All counters and output registers.
    always_ff @(posedge CLK_100MHZ or posedge RESET) begin
        if (RESET) begin
            tick_cnt_q <= '0;
            win_cnt_q  <= '0;
            lane_cnt_q <= '{default: '0};
            t_q        <= '0;
            last_cnt_q <= '0;
            win_done_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            win_cnt_q  <= win_cnt_d;
            lane_cnt_q <= lane_cnt_d;
            t_q        <= t_d;
            last_cnt_q <= last_cnt_d;
            win_done_q <= terminal;
        end
    end

    assign bus.T        = t_q;
    assign bus.LAST_CNT = last_cnt_q;
    assign bus.WIN_DONE = win_done_q;

endmodule
